// File: rtl/exanet_arb_pkg.sv
// Shared sizing, state encoding and VC helpers for the Exanet switch arbiters.
// Input-side VC allocators import the same widths so the VC id layout stays consistent.
package exanet_arb_pkg;

  localparam int VC_NUM      = 3;
  localparam int PRIO_NUM    = 2;
  localparam int INPUT_NUM   = 8;
  localparam int MAX_CREDITS = 8;

  localparam int VC_TOTAL = VC_NUM * PRIO_NUM;
  localparam int VCW      = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;
  localparam int PRIOW    = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;
  localparam int INW      = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int CREDW    = $clog2(MAX_CREDITS + 1);

  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;

  // VC ids are laid out as prio*VC_NUM + vc, so the class is a plain division.
  function automatic logic [PRIOW-1:0] vc_prio(input logic [VCW-1:0] vc_id);
    return PRIOW'(int'(vc_id) / VC_NUM);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  // Walk from the farthest position back to ptr so the last hit is the nearest one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/output_vc_arbiter.sv
// Per-output packet arbiter with downstream per-VC credit tracking.
// Define OUTPUT_ARB_STRICT_PRIO_EN to let only the highest requested priority class compete.
module output_vc_arbiter
  import exanet_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [INPUT_NUM-1:0]     req_valid,
  input  logic [INPUT_NUM*VCW-1:0] req_vc,
  input  logic                     flit_accept,
  input  logic                     last,
  input  logic [VC_TOTAL-1:0]      credit_return,
  output logic [INPUT_NUM-1:0]     grant,
  output logic [VCW-1:0]           grant_vc,
  output logic                     flit_ready,
  output logic [VC_TOTAL-1:0]      credit_avail
);

  arb_state_t           state, state_next;
  logic [INW-1:0]       rr_ptr, rr_ptr_next;
  logic [INPUT_NUM-1:0] grant_next;
  logic [VCW-1:0]       grant_vc_next;
  logic [CREDW-1:0]     credit [VC_TOTAL];
  logic [VC_TOTAL-1:0]  take;
  logic [INPUT_NUM-1:0] eligible, compete, rr_gnt;
  logic [INW-1:0]       rr_idx;
  logic [VCW-1:0]       cur_vc;
  logic                 flit_counted;

  always_comb begin
    credit_avail = '0;
    take         = '0;
    for (int v = 0; v < VC_TOTAL; v++) begin
      credit_avail[v] = (credit[v] != '0);
      take[v]         = flit_counted && (grant_vc == VCW'(v));
    end
  end

  // VC ids beyond the configured range are never eligible.
  always_comb begin
    eligible = '0;
    cur_vc   = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      cur_vc      = req_vc[i*VCW +: VCW];
      eligible[i] = req_valid[i] && (int'(cur_vc) < VC_TOTAL) && credit_avail[cur_vc];
    end
  end

`ifdef OUTPUT_ARB_STRICT_PRIO_EN
  logic [PRIOW-1:0] top_prio;

  always_comb begin
    top_prio = '0;
    compete  = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (eligible[i] && (vc_prio(req_vc[i*VCW +: VCW]) > top_prio))
        top_prio = vc_prio(req_vc[i*VCW +: VCW]);
    end
    for (int i = 0; i < INPUT_NUM; i++)
      compete[i] = eligible[i] && (vc_prio(req_vc[i*VCW +: VCW]) == top_prio);
  end
`else
  assign compete = eligible;
`endif

  rr_arbiter #(.N(INPUT_NUM)) u_rr (
    .req     (compete),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  assign flit_ready   = (state == ARB_GRANTED) && credit_avail[grant_vc];
  assign flit_counted = flit_accept && flit_ready;

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    grant_vc_next = grant_vc;
    rr_ptr_next   = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|compete) begin
          state_next    = ARB_GRANTED;
          grant_next    = rr_gnt;
          grant_vc_next = req_vc[int'(rr_idx)*VCW +: VCW];
          rr_ptr_next   = (rr_idx == INW'(INPUT_NUM - 1)) ? '0 : rr_idx + 1'b1;
        end
      end
      ARB_GRANTED: begin
        if (flit_counted && last) begin
          state_next = ARB_IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_vc <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      grant_vc <= grant_vc_next;
      rr_ptr   <= rr_ptr_next;
    end
  end

  // A return and a consumed flit on the same VC cancel; returns at full depth saturate.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int v = 0; v < VC_TOTAL; v++) credit[v] <= CREDW'(MAX_CREDITS);
    end else begin
      for (int v = 0; v < VC_TOTAL; v++) begin
        if (credit_return[v] && !take[v]) begin
          if (credit[v] != CREDW'(MAX_CREDITS)) credit[v] <= credit[v] + 1'b1;
        end else if (take[v] && !credit_return[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
    end
  end

  for (genvar v = 0; v < VC_TOTAL; v++) begin : g_credit_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
      !(credit_return[v] && !take[v] && (credit[v] == CREDW'(MAX_CREDITS))));
  end

endmodule

// File: tb/tb_output_vc_arbiter.sv
// Self-checking bench for output_vc_arbiter: directed vectors, corner sequences and a random run
// against a queue-free behavioural model. Honours OUTPUT_ARB_STRICT_PRIO_EN.
module tb_output_vc_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  req_valid = '0;
  logic [23:0] req_vc = '0;
  logic        flit_accept = 1'b0;
  logic        last = 1'b0;
  logic [5:0]  credit_return = '0;
  logic [7:0]  grant;
  logic [2:0]  grant_vc;
  logic        flit_ready;
  logic [5:0]  credit_avail;

  int total = 0;
  int bad = 0;

`ifdef OUTPUT_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  output_vc_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_vc        (req_vc),
    .flit_accept   (flit_accept),
    .last          (last),
    .credit_return (credit_return),
    .grant         (grant),
    .grant_vc      (grant_vc),
    .flit_ready    (flit_ready),
    .credit_avail  (credit_avail)
  );

  always #5 clk = ~clk;

  // Reference model: packet owner, rotating start point and a plain credit count per VC.
  int m_cred[6];
  bit m_busy;
  int m_gnt, m_gvc, m_ptr;

  function automatic int vc_of(input int i);
    logic [23:0] v;
    v = req_vc;
    return int'(v[i*3 +: 3]);
  endfunction

  function automatic bit elig(input int i);
    return req_valid[i] && vc_of(i) < 6 && m_cred[vc_of(i)] > 0;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 6; v++) m_cred[v] = 8;
    m_busy = 0; m_gnt = 0; m_gvc = 0; m_ptr = 0;
  endtask

  task automatic model_update();
    bit counted;
    int old_gvc, top, win, idx, d;
    old_gvc = m_gvc;
    counted = flit_accept && m_busy && m_cred[m_gvc] > 0;
    if (!m_busy) begin
      top = -1;
      for (int i = 0; i < 8; i++) if (elig(i) && vc_of(i) / 3 > top) top = vc_of(i) / 3;
      win = -1;
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (win < 0 && elig(idx) && (!STRICT || vc_of(idx) / 3 == top)) win = idx;
      end
      if (win >= 0) begin
        m_busy = 1; m_gnt = win; m_gvc = vc_of(win); m_ptr = (win + 1) % 8;
      end
    end else if (counted && last) begin
      m_busy = 0;
    end
    for (int v = 0; v < 6; v++) begin
      d = int'(credit_return[v]) - ((counted && old_gvc == v) ? 1 : 0);
      m_cred[v] = m_cred[v] + d;
      if (m_cred[v] > 8) m_cred[v] = 8;
      if (m_cred[v] < 0) m_cred[v] = 0;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    logic [5:0] ea;
    eg = m_busy ? 8'(1 << m_gnt) : 8'h00;
    for (int v = 0; v < 6; v++) ea[v] = m_cred[v] > 0;
    check_output("model_grant", 32'(grant), 32'(eg));
    check_output("model_ready", 32'(flit_ready), 32'(m_busy && m_cred[m_gvc] > 0));
    check_output("model_avail", 32'(credit_avail), 32'(ea));
    if (m_busy) check_output("model_grant_vc", 32'(grant_vc), 32'(m_gvc));
  endtask

  // Drive one cycle of inputs, step the model on the edge, return on the next falling edge.
  task automatic apply_stimulus(input logic [7:0] rv, input logic [23:0] vcs, input logic fa,
                                input logic lst, input logic [5:0] cr);
    req_valid = rv; req_vc = vcs; flit_accept = fa; last = lst; credit_return = cr;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0; req_vc = '0; flit_accept = 1'b0; last = 1'b0; credit_return = '0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  rv;
    logic [23:0] vcs;
    logic        fa;
    logic        lst;
    logic [5:0]  cr;
    logic [7:0]  e_grant;
    logic        e_ready;
    logic [5:0]  e_avail;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b0000_0101, 24'h0, 1'b0, 1'b0, 6'h00, 8'b0000_0001, 1'b1, 6'h3f};
    vecs[1] = '{8'b0000_0101, 24'h0, 1'b1, 1'b1, 6'h00, 8'b0000_0000, 1'b0, 6'h3f};
    vecs[2] = '{8'b0000_0101, 24'h0, 1'b0, 1'b0, 6'h00, 8'b0000_0100, 1'b1, 6'h3f};
    vecs[3] = '{8'b0000_0101, 24'h0, 1'b1, 1'b1, 6'h00, 8'b0000_0000, 1'b0, 6'h3f};
    vecs[4] = '{8'b0000_0101, 24'h0, 1'b0, 1'b0, 6'h00, 8'b0000_0001, 1'b1, 6'h3f};
    vecs[5] = '{8'b0000_0101, 24'h0, 1'b1, 1'b1, 6'h01, 8'b0000_0000, 1'b0, 6'h3f};
    vecs[6] = '{8'b0000_0000, 24'h0, 1'b0, 1'b0, 6'h00, 8'b0000_0000, 1'b0, 6'h3f};
    vecs[7] = '{8'b0000_0000, 24'h0, 1'b1, 1'b1, 6'h00, 8'b0000_0000, 1'b0, 6'h3f};

    do_reset();
    check_output("reset_grant", 32'(grant), 32'h0);
    check_output("reset_ready", 32'(flit_ready), 32'h0);
    check_output("reset_avail", 32'(credit_avail), 32'h3f);

    // Round-robin between inputs 0 and 2 on vc 0.
    for (int n = 0; n < 8; n++) begin
      apply_stimulus(vecs[n].rv, vecs[n].vcs, vecs[n].fa, vecs[n].lst, vecs[n].cr);
      check_output($sformatf("vec%0d_grant", n), 32'(grant), 32'(vecs[n].e_grant));
      check_output($sformatf("vec%0d_ready", n), 32'(flit_ready), 32'(vecs[n].e_ready));
      check_output($sformatf("vec%0d_avail", n), 32'(credit_avail), 32'(vecs[n].e_avail));
    end

    // Input 3 on vc 1 drains all eight credits, then stalls until one returns.
    do_reset();
    apply_stimulus(8'b0000_1000, 24'(1) << 9, 1'b0, 1'b0, 6'h00);
    check_output("drain_grant", 32'(grant), 32'h08);
    check_output("drain_grant_vc", 32'(grant_vc), 32'h1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'b0000_1000, 24'(1) << 9, 1'b1, 1'b0, 6'h00);
      check_output($sformatf("drain_ready%0d", i), 32'(flit_ready), 32'(i < 7));
    end
    check_output("drain_avail", 32'(credit_avail), 32'h3d);
    apply_stimulus(8'b0000_1000, 24'(1) << 9, 1'b1, 1'b0, 6'h00);
    check_output("stall_grant", 32'(grant), 32'h08);
    check_output("stall_ready", 32'(flit_ready), 32'h0);
    apply_stimulus(8'b0000_0000, 24'h0, 1'b0, 1'b0, 6'h02);
    check_output("resume_ready", 32'(flit_ready), 32'h1);
    check_output("resume_avail", 32'(credit_avail), 32'h3f);
    apply_stimulus(8'b0000_0000, 24'h0, 1'b1, 1'b1, 6'h00);
    check_output("drain_end_grant", 32'(grant), 32'h0);

    // Consume and return on vc 2 in the same cycle at credit 5.
    do_reset();
    apply_stimulus(8'b0000_0001, 24'h2, 1'b0, 1'b0, 6'h00);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h00);
    apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h04);
    check_output("same_avail", 32'(credit_avail), 32'h3f);
    for (int i = 0; i < 4; i++) apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h00);
    check_output("same_ready_at1", 32'(flit_ready), 32'h1);
    apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h00);
    check_output("same_ready_at0", 32'(flit_ready), 32'h0);

    // Reset in the middle of a packet with credit[0]=3.
    do_reset();
    apply_stimulus(8'b0000_0011, 24'h0, 1'b0, 1'b0, 6'h00);
    check_output("midrst_grant_before", 32'(grant), 32'h01);
    for (int i = 0; i < 5; i++) apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h00);
    #2;
    resetn = 1'b0;
    flit_accept = 1'b0;
    #1;
    check_output("midrst_grant", 32'(grant), 32'h0);
    check_output("midrst_ready", 32'(flit_ready), 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    check_output("midrst_avail", 32'(credit_avail), 32'h3f);
    apply_stimulus(8'b0000_0011, 24'h0, 1'b0, 1'b0, 6'h00);
    check_output("midrst_regrant", 32'(grant), 32'h01);
    for (int i = 0; i < 8; i++) apply_stimulus(8'h00, 24'h0, 1'b1, 1'b0, 6'h00);
    check_output("midrst_reload", 32'(credit_avail), 32'h3e);

    // Input 2 on an empty vc 0 is skipped until a credit comes back.
    do_reset();
    apply_stimulus(8'b0000_0100, 24'h0, 1'b0, 1'b0, 6'h00);
    for (int i = 0; i < 8; i++) apply_stimulus(8'h00, 24'h0, 1'b1, i == 7, 6'h00);
    check_output("starve_idle", 32'(grant), 32'h0);
    apply_stimulus(8'b0100_0100, 24'(1) << 18, 1'b0, 1'b0, 6'h00);
    check_output("starve_grant6", 32'(grant), 32'h40);
    apply_stimulus(8'b0100_0100, 24'(1) << 18, 1'b1, 1'b1, 6'h00);
    apply_stimulus(8'b0100_0100, 24'(1) << 18, 1'b0, 1'b0, 6'h00);
    check_output("starve_grant6_again", 32'(grant), 32'h40);
    apply_stimulus(8'b0100_0100, 24'(1) << 18, 1'b1, 1'b1, 6'h01);
    apply_stimulus(8'b0100_0100, 24'(1) << 18, 1'b0, 1'b0, 6'h00);
    check_output("starve_grant2", 32'(grant), 32'h04);

    // Priority classes: input 0 on vc 1 vs input 5 on vc 4.
    do_reset();
    apply_stimulus(8'b0010_0001, 24'h1 | (24'h4 << 15), 1'b0, 1'b0, 6'h00);
    check_output("prio_grant", 32'(grant), STRICT ? 32'h20 : 32'h01);

    // Random traffic against the model; returns only where the model has room.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [23:0] vcs;
      logic [5:0]  cr;
      for (int i = 0; i < 8; i++) vcs[i*3 +: 3] = 3'($urandom_range(0, 5));
      for (int v = 0; v < 6; v++) cr[v] = (m_cred[v] < 8) && ($urandom_range(0, 2) == 0);
      apply_stimulus(8'($urandom), vcs, 1'($urandom), $urandom_range(0, 3) == 0, cr);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
